load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns execute-stage memory accesses into single bus transactions
// and returns extended load data. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  opcode,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] load_data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    function automatic size_t decode_size(input logic [5:0] op);
        case (op)
            6'b100000, 6'b100100, 6'b101000: decode_size = SZ_BYTE;
            6'b100001, 6'b100101, 6'b101001: decode_size = SZ_HALF;
            default:                         decode_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic decode_signed(input logic [5:0] op);
        case (op)
            6'b100000, 6'b100001: decode_signed = 1'b1;
            default:              decode_signed = 1'b0;
        endcase
    endfunction

    // Halfword and word accesses drop the address bits below their natural alignment.
    function automatic logic [31:0] effective_addr(input size_t sz, input logic [31:0] a);
        case (sz)
            SZ_HALF: effective_addr = {a[31:1], 1'b0};
            SZ_WORD: effective_addr = {a[31:2], 2'b00};
            default: effective_addr = a;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: is_misaligned = lo[0];
            SZ_WORD: is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction
`endif

    function automatic logic [3:0] byte_enables(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: byte_enables = 4'b0001 << lo;
            SZ_HALF: byte_enables = 4'b0011 << {lo[1], 1'b0};
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate_wdata(input size_t sz, input logic [31:0] d);
        case (sz)
            SZ_BYTE: replicate_wdata = {4{d[7:0]}};
            SZ_HALF: replicate_wdata = {2{d[15:0]}};
            default: replicate_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] extract_load(input size_t sz, input logic sgn,
                                                 input logic [1:0] lo, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (sz)
            SZ_BYTE: extract_load = {{24{sgn & b[7]}}, b};
            SZ_HALF: extract_load = {{16{sgn & h[15]}}, h};
            default: extract_load = rd;
        endcase
    endfunction

    state_t           state_r;
    size_t            size_r;
    logic             signed_r;
    logic [1:0]       lo_r;
    logic [CNT_W-1:0] cnt_r;

    logic             access_s;
    logic             is_store_s;
    size_t            size_s;
    logic [31:0]      eff_addr_s;
    logic [31:0]      load_val_s;
`ifdef LSU_MISALIGN_TRAP_EN
    logic             misalign_s;
`endif

    assign access_s   = req_valid & (MemRead | MemWrite);
    assign is_store_s = MemWrite;
    assign size_s     = decode_size(opcode);
    assign eff_addr_s = effective_addr(size_s, ALUResult);
    assign load_val_s = extract_load(size_r, signed_r, lo_r, mem_rdata);
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_s = is_misaligned(size_s, ALUResult[1:0]);
`endif

    // Stall must rise in the same cycle the access is presented, so it is decoded from state.
    assign stall = ((state_r == IDLE) && access_s) || (state_r == REQ);

    // Access sequencer with registered bus and writeback outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            size_r    <= SZ_WORD;
            signed_r  <= 1'b0;
            lo_r      <= 2'b00;
            cnt_r     <= '0;
            wb_valid  <= 1'b0;
            err       <= 1'b0;
            load_data <= 32'h0000_0000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            mem_be    <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    wb_valid <= 1'b0;
                    err      <= 1'b0;
                    if (access_s) begin
                        size_r   <= size_s;
                        signed_r <= decode_signed(opcode);
                        lo_r     <= eff_addr_s[1:0];
                        cnt_r    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misalign_s) begin
                            state_r   <= DONE;
                            wb_valid  <= 1'b1;
                            err       <= 1'b1;
                            load_data <= 32'h0000_0000;
                            mem_req   <= 1'b0;
                            mem_we    <= 1'b0;
                        end else begin
`else
                        begin
`endif
                            state_r   <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store_s;
                            mem_addr  <= {eff_addr_s[31:2], 2'b00};
                            mem_be    <= is_store_s ? byte_enables(size_s, eff_addr_s[1:0]) : 4'b0000;
                            mem_wdata <= is_store_s ? replicate_wdata(size_s, ReadData2) : 32'h0000_0000;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_r   <= DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        wb_valid  <= 1'b1;
                        err       <= 1'b0;
                        load_data <= mem_we ? 32'h0000_0000 : load_val_s;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r   <= DONE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        wb_valid  <= 1'b1;
                        err       <= 1'b1;
                        load_data <= 32'h0000_0000;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_r  <= IDLE;
                    wb_valid <= 1'b0;
                    err      <= 1'b0;
                    cnt_r    <= '0;
                end
                default: begin
                    state_r  <= IDLE;
                    wb_valid <= 1'b0;
                    err      <= 1'b0;
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    cnt_r    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single accesses plus
// hand-written timeout, ack-outside-REQ, reset-mid-access and trap sequences.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [5:0]  opcode;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] ReadData2;
    logic        stall;
    logic        wb_valid;
    logic [31:0] load_data;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .opcode(opcode),
        .MemRead(MemRead), .MemWrite(MemWrite), .ALUResult(ALUResult), .ReadData2(ReadData2),
        .stall(stall), .wb_valid(wb_valid), .load_data(load_data), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  op;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          ack_dly;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
        opcode    = 6'd0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        ALUResult = 32'h0;
        ReadData2 = 32'h0;
    endtask

    task automatic add(input logic [5:0] op, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdat, input logic [31:0] rdat, input int dly,
                       input logic [31:0] e_addr, input logic [3:0] e_be, input logic e_we,
                       input logic [31:0] e_wdata, input logic [31:0] e_load);
        vec_t v;
        v.op = op; v.rd = rd; v.wr = wr; v.addr = addr; v.wdat = wdat; v.rdat = rdat;
        v.ack_dly = dly; v.e_addr = e_addr; v.e_be = e_be; v.e_we = e_we;
        v.e_wdata = e_wdata; v.e_load = e_load;
        vecs.push_back(v);
    endtask

    task automatic present(input logic [5:0] op, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdat);
        @(negedge clock);
        req_valid = 1'b1; opcode = op; MemRead = rd; MemWrite = wr;
        ALUResult = addr; ReadData2 = wdat;
    endtask

    task automatic run_vec(input vec_t t, input int i);
        present(t.op, t.rd, t.wr, t.addr, t.wdat);
        #1 chk($sformatf("v%0d_stall_idle", i), {31'd0, stall}, 32'd1);
        @(negedge clock);
        drive_idle();
        chk($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, 32'd1);
        chk($sformatf("v%0d_mem_addr", i), mem_addr, t.e_addr);
        chk($sformatf("v%0d_mem_be", i), {28'd0, mem_be}, {28'd0, t.e_be});
        chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, t.e_we});
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, t.e_wdata);
        chk($sformatf("v%0d_stall_req", i), {31'd0, stall}, 32'd1);
        repeat (t.ack_dly) @(negedge clock);
        chk($sformatf("v%0d_addr_held", i), mem_addr, t.e_addr);
        mem_ack = 1'b1; mem_rdata = t.rdat;
        @(negedge clock);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid}, 32'd1);
        chk($sformatf("v%0d_load_data", i), load_data, t.e_load);
        chk($sformatf("v%0d_err", i), {31'd0, err}, 32'd0);
        chk($sformatf("v%0d_stall_done", i), {31'd0, stall}, 32'd0);
        chk($sformatf("v%0d_req_drop", i), {31'd0, mem_req}, 32'd0);
        @(negedge clock);
        chk($sformatf("v%0d_wb_pulse", i), {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        int req_cycles;
        int stall_bad;
        int wb_seen;
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        drive_idle();

        //   op        rd    wr    addr          wdata         rdata         dly  e_addr        e_be     we    e_wdata       e_load
        add(6'b100011, 1'b1, 1'b0, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 1, 32'h0000_1004, 4'b0000, 1'b0, 32'h0,        32'hDEAD_BEEF);
        add(6'b100000, 1'b1, 1'b0, 32'h0000_1003, 32'h0,        32'h8000_0000, 0, 32'h0000_1000, 4'b0000, 1'b0, 32'h0,        32'hFFFF_FF80);
        add(6'b100100, 1'b1, 1'b0, 32'h0000_1003, 32'h0,        32'h8000_0000, 2, 32'h0000_1000, 4'b0000, 1'b0, 32'h0,        32'h0000_0080);
        add(6'b101001, 1'b0, 1'b1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        1, 32'h0000_2000, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0);
        add(6'b101000, 1'b0, 1'b1, 32'h0000_3001, 32'h0000_00A5, 32'h0,        0, 32'h0000_3000, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h0);
        add(6'b100001, 1'b1, 1'b0, 32'h0000_1002, 32'h0,        32'h8001_1234, 3, 32'h0000_1000, 4'b0000, 1'b0, 32'h0,        32'hFFFF_8001);
        add(6'b100101, 1'b1, 1'b0, 32'h0000_1000, 32'h0,        32'h8001_F234, 1, 32'h0000_1000, 4'b0000, 1'b0, 32'h0,        32'h0000_F234);
        add(6'b101011, 1'b1, 1'b1, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,        1, 32'h0000_4000, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0);
        add(6'b000000, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'h0BAD_F00D, 0, 32'h0000_0010, 4'b0000, 1'b0, 32'h0,        32'h0BAD_F00D);
        add(6'b100000, 1'b1, 1'b0, 32'h0000_2002, 32'h0,        32'h007F_0000, 1, 32'h0000_2000, 4'b0000, 1'b0, 32'h0,        32'h0000_007F);
`ifndef LSU_MISALIGN_TRAP_EN
        add(6'b100011, 1'b1, 1'b0, 32'h0000_1002, 32'h0,        32'h1122_3344, 1, 32'h0000_1000, 4'b0000, 1'b0, 32'h0,        32'h1122_3344);
        add(6'b100001, 1'b1, 1'b0, 32'h0000_1003, 32'h0,        32'h7FFF_0000, 1, 32'h0000_1000, 4'b0000, 1'b0, 32'h0,        32'h0000_7FFF);
        add(6'b101001, 1'b0, 1'b1, 32'h0000_5001, 32'hFFFF_5678, 32'h0,        0, 32'h0000_5000, 4'b0011, 1'b1, 32'h5678_5678, 32'h0);
`endif

        repeat (2) @(negedge clock);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Timeout: prime load_data with a nonzero value, then never acknowledge.
        run_vec(vecs[0], 100);
        present(6'b100011, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        @(negedge clock);
        drive_idle();
        req_cycles = 0; stall_bad = 0;
        for (int k = 0; k < 64 && !wb_valid; k++) begin
            if (mem_req) req_cycles++;
            if (!stall) stall_bad++;
            @(negedge clock);
        end
        chk("to_req_cycles", req_cycles, 32'd16);
        chk("to_stall_in_req", stall_bad, 32'd0);
        chk("to_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_load_data", load_data, 32'h0);
        @(negedge clock);
        chk("to_err_clear", {31'd0, err}, 32'd0);
        chk("to_wb_pulse", {31'd0, wb_valid}, 32'd0);

        // Ack while idle must be ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        chk("idle_ack_wb", {31'd0, wb_valid}, 32'd0);
        chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0; mem_rdata = 32'h0;

        // Reset in the middle of a store transaction.
        present(6'b101011, 1'b0, 1'b1, 32'h0000_6000, 32'h0000_0055);
        @(negedge clock);
        drive_idle();
        chk("mid_req_up", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_wdata", mem_wdata, 32'h0);
        chk("mid_rst_be", {28'd0, mem_be}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        wb_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (wb_valid) wb_seen++;
        end
        chk("mid_rst_no_wb", wb_seen, 32'd0);
        run_vec(vecs[0], 200);

`ifdef LSU_MISALIGN_TRAP_EN
        present(6'b100011, 1'b1, 1'b0, 32'h0000_1002, 32'h0);
        @(negedge clock);
        drive_idle();
        chk("trap_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("trap_err", {31'd0, err}, 32'd1);
        chk("trap_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clock);
        chk("trap_wb_pulse", {31'd0, wb_valid}, 32'd0);
        chk("trap_mem_req_after", {31'd0, mem_req}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
